// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame checker: parity mode and
// FSM state encodings plus the expected-parity-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'b000,
        PAR_EVEN  = 3'b001,
        PAR_ODD   = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP1  = 3'd3,
        ST_STOP2  = 3'd4
    } state_e;

    // Reserved encodings 101..111 collapse to PAR_NONE.
    function automatic par_mode_e par_mode_norm(input logic [2:0] mode);
        case (mode)
            3'b001:  return PAR_EVEN;
            3'b010:  return PAR_ODD;
            3'b011:  return PAR_MARK;
            3'b100:  return PAR_SPACE;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic par_expected(input par_mode_e mode, input logic acc);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_frame_chk_if.sv
// Bit-stream, control and status bundle between the sampler side (master)
// and the frame checker (slave).
interface uart_rx_frame_chk_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  bit_vld;
    logic                  sampled_bit;
    logic [2:0]            par_mode;
    logic                  two_stop;
    logic                  abort;
    logic                  clr_sts;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  frame_vld;
    logic                  par_err;
    logic                  stp_err;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;
    logic                  busy;

    modport master (
        output bit_vld, sampled_bit, par_mode, two_stop, abort, clr_sts,
        input  P_DATA, frame_vld, par_err, stp_err, PAR_ERR, STP_ERR,
               par_err_cnt, stp_err_cnt, busy
    );

    modport slave (
        input  bit_vld, sampled_bit, par_mode, two_stop, abort, clr_sts,
        output P_DATA, frame_vld, par_err, stp_err, PAR_ERR, STP_ERR,
               par_err_cnt, stp_err_cnt, busy
    );
endinterface

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with synchronous clear that takes priority over inc.
module uart_sat_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: deserialises qualified bits, checks parity and
// stop bits, and reports per-frame flags, sticky flags and error counters.
module uart_rx_frame_chk
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input logic               CLK,
    input logic               RST,
    uart_rx_frame_chk_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    state_e                state_q;
    par_mode_e             mode_q;
    logic                  two_stop_q;
    logic [CW-1:0]         cnt_q;
    logic                  acc_q;
    logic                  perr_q;
    logic                  serr_q;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  frame_vld_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  par_sticky_q;
    logic                  stp_sticky_q;
    logic                  busy_q;

    logic                  frame_done_d;
    logic                  serr_d;

    // Completion is decided combinationally so the counters step on the same edge.
    always_comb begin
        frame_done_d = 1'b0;
        serr_d       = serr_q | ~bus.sampled_bit;
        if (bus.bit_vld && !bus.abort) begin
            case (state_q)
                ST_STOP1: frame_done_d = ~two_stop_q;
                ST_STOP2: frame_done_d = 1'b1;
                default:  frame_done_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            mode_q       <= PAR_NONE;
            two_stop_q   <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            serr_q       <= 1'b0;
            shadow_q     <= '0;
            p_data_q     <= '0;
            frame_vld_q  <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_sticky_q <= 1'b0;
            stp_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            if (bus.abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (bus.bit_vld) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!bus.sampled_bit) begin
                            state_q    <= ST_DATA;
                            busy_q     <= 1'b1;
                            mode_q     <= par_mode_norm(bus.par_mode);
                            two_stop_q <= bus.two_stop;
                            cnt_q      <= '0;
                            acc_q      <= 1'b0;
                            perr_q     <= 1'b0;
                            serr_q     <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (cnt_q == CW'(i)) shadow_q[i] <= bus.sampled_bit;
                        end
                        acc_q <= acc_q ^ bus.sampled_bit;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        perr_q  <= (bus.sampled_bit != par_expected(mode_q, acc_q));
                        state_q <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        serr_q  <= serr_d;
                        state_q <= two_stop_q ? ST_STOP2 : ST_IDLE;
                    end
                    ST_STOP2: begin
                        serr_q  <= serr_d;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase

                if (frame_done_d) begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    frame_vld_q <= 1'b1;
                    p_data_q    <= shadow_q;
                    par_err_q   <= perr_q;
                    stp_err_q   <= serr_d;
                end
            end

            if (bus.clr_sts) begin
                par_sticky_q <= 1'b0;
                stp_sticky_q <= 1'b0;
            end else if (frame_done_d) begin
                if (perr_q) par_sticky_q <= 1'b1;
                if (serr_d) stp_sticky_q <= 1'b1;
            end
        end
    end

    uart_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr_i (bus.clr_sts),
        .inc_i (frame_done_d & perr_q),
        .cnt_o (bus.par_err_cnt)
    );

    uart_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr_i (bus.clr_sts),
        .inc_i (frame_done_d & serr_d),
        .cnt_o (bus.stp_err_cnt)
    );

    assign bus.P_DATA    = p_data_q;
    assign bus.frame_vld = frame_vld_q;
    assign bus.par_err   = par_err_q;
    assign bus.stp_err   = stp_err_q;
    assign bus.PAR_ERR   = par_sticky_q;
    assign bus.STP_ERR   = stp_sticky_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/uart_rx_frame_chk.md
# uart_rx_frame_chk

Parametrised UART receive frame checker, the successor to the fixed 8-bit parity checker. It consumes the sampler's bit stream one qualified bit at a time and accumulates data and parity serially. It checks parity in five runtime modes and checks one or two stop bits. For each frame it emits the data word, per-frame error flags, sticky status and saturating error counters for the deserializer/FSM layer.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CNT_WIDTH, 8: width of each saturating error counter.

- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- bit_vld  in  1  one-cycle strobe; sampled_bit is valid this cycle.
- sampled_bit  in  1  majority-sampled line value.
- par_mode  in  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101..111 treated as none.
- two_stop  in  1  1 = two stop bits expected.
- abort  in  1  drop the frame in progress.
- clr_sts  in  1  clear sticky flags and counters.
- P_DATA  out  DATA_WIDTH  last completed data word, LSB = first data bit.
- frame_vld  out  1  one-cycle pulse when a frame completes.
- par_err  out  1  parity result of the last frame; updated with frame_vld.
- stp_err  out  1  stop result of the last frame; updated with frame_vld.
- PAR_ERR  out  1  sticky parity error.
- STP_ERR  out  1  sticky stop error.
- par_err_cnt  out  CNT_WIDTH  saturating parity-error count.
- stp_err_cnt  out  CNT_WIDTH  saturating stop-error count.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - bit_vld with sampled_bit=0 is accepted as the start bit.
  - par_mode and two_stop are latched at this point; the data counter and parity accumulator are cleared; next state is DATA.
  - bit_vld with sampled_bit=1 is ignored.
- DATA:
  - Each bit_vld shifts sampled_bit into the shadow register at index cnt and XORs it into acc.
  - After DATA_WIDTH bits, the next state is PARITY if the latched mode is not none; otherwise STOP1.
- PARITY:
  - Expected bit: even = acc; odd = ~acc; mark = 1; space = 0.
  - perr_int = (sampled_bit != expected).
- STOP1:
  - serr_int = ~sampled_bit.
  - Next state is STOP2 if two_stop was latched; otherwise the frame completes.
- STOP2:
  - serr_int |= ~sampled_bit; the frame completes.
  - STOP1 errors do not end the frame early.
- Frame completion, in the same update:
  - P_DATA <= shadow register; par_err <= perr_int (0 in mode none); stp_err <= serr_int.
  - PAR_ERR/STP_ERR are set when the matching flag is set.
  - The matching counter increments, saturating at 2^CNT_WIDTH-1.
  - Next state is IDLE.
- Cycles without bit_vld hold all state; no timeout.
- abort:
  - The next state is IDLE; no frame_vld is issued.
  - P_DATA, par_err, stp_err, sticky flags and counters are unchanged.
  - abort wins over a coincident final stop bit.
- clr_sts:
  - Synchronously zeroes PAR_ERR, STP_ERR and both counters.
  - When it coincides with frame completion, clear wins for sticky flags and counters (result 0), but par_err/stp_err/P_DATA still update.
- Reset values: all outputs 0; FSM in IDLE; internal registers 0. Reset mid-frame discards the frame.

## Timing
- All outputs are registered.
- frame_vld is high exactly one CLK after the bit_vld cycle of the final stop bit; P_DATA, par_err, stp_err, sticky flags and counters are valid in that same cycle.
- busy rises in the cycle after the start bit is accepted and falls in the cycle frame_vld is high.
- A start bit may be accepted in the cycle frame_vld is high, so back-to-back frames are supported.
- Frame length in bit_vld strobes: 1 + DATA_WIDTH + (parity enabled ? 1 : 0) + (two_stop ? 2 : 1).
- par_mode/two_stop changes while busy take effect only at the next start bit.

## Structure
- Shared package uart_pkg:
  - par_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE).
  - FSM state encoding.
  - Parity expected-bit function.
- One sub-module, uart_sat_cnt: CNT_WIDTH saturating counter with inc/clr inputs (clear priority); instantiated twice.
- Data counter width: $clog2(DATA_WIDTH+1).

## Test plan
- DATA_WIDTH=8, even, one stop; feed 0, 1,0,1,0,0,1,0,1, 0, 1 -> frame_vld one cycle after the last bit_vld, P_DATA=0xA5, par_err=0, stp_err=0, counters 0.
- Same frame with par_mode=odd -> par_err=1, PAR_ERR=1, par_err_cnt=1; the next clean even frame leaves par_err=0 and PAR_ERR=1.
- two_stop=1, data 0x3C, mark parity bit 1, stops 1 then 0 -> stp_err=1, stp_err_cnt=1; frame_vld only after the second stop bit.
- CNT_WIDTH=2, five odd-parity-error frames -> par_err_cnt holds 3; clr_sts coincident with a sixth error frame -> par_err_cnt=0, PAR_ERR=0, par_err=1.
- abort after 4 data bits, then a clean 0x5A frame in mode none -> exactly one frame_vld, P_DATA=0x5A; par_mode changed mid-frame does not alter that frame's length.
- RST asserted mid-frame, with unclocked bit_vld gaps of varying length -> all outputs 0, busy=0; gaps do not change results.
